// File: rtl/chacha_keystream_sched_if.sv
// Bundles the command, ChaCha-core and keystream signals of the block sequencer.
// The slave modport is the sequencer's view; master is the view of whatever drives it.
interface chacha_keystream_sched_if #(
    parameter int NB_W = 16
);
    logic            start_i;
    logic            abort_i;
    logic [NB_W-1:0] num_blocks_i;
    logic [31:0]     ctr_init_i;
    logic            core_start_o;
    logic [31:0]     core_ctr_o;
    logic            core_done_i;
    logic [511:0]    core_block_i;
    logic            ks_valid_o;
    logic            ks_ready_i;
    logic [31:0]     ks_data_o;
    logic            ks_last_o;
    logic            busy_o;
    logic            done_o;
    logic            err_wrap_o;
    logic            err_tmo_o;
    logic [NB_W-1:0] blocks_done_o;

    modport slave (
        input  start_i, abort_i, num_blocks_i, ctr_init_i, core_done_i, core_block_i, ks_ready_i,
        output core_start_o, core_ctr_o, ks_valid_o, ks_data_o, ks_last_o,
               busy_o, done_o, err_wrap_o, err_tmo_o, blocks_done_o
    );

    modport master (
        output start_i, abort_i, num_blocks_i, ctr_init_i, core_done_i, core_block_i, ks_ready_i,
        input  core_start_o, core_ctr_o, ks_valid_o, ks_data_o, ks_last_o,
               busy_o, done_o, err_wrap_o, err_tmo_o, blocks_done_o
    );
endinterface

// File: rtl/chacha_keystream_sched.sv
// Issues N counter-stamped block requests to the ChaCha core, double-buffers the
// 512-bit results and streams them out as 32-bit keystream words.
module chacha_keystream_sched #(
    parameter int TIMEOUT = 1024,
    parameter int NB_W    = 16
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rstn_i,
    chacha_keystream_sched_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_FLUSH
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       ctr_q, ctr_d;
    logic [NB_W-1:0]   remaining_q, remaining_d;
    logic [NB_W-1:0]   blocks_done_q, blocks_done_d;
    logic              err_wrap_q, err_wrap_d;
    logic              err_tmo_q, err_tmo_d;
    logic              done_q, done_d;
    logic [CW-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic [1:0]        full_q, full_d;
    logic [1:0]        last_q, last_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [3:0]        word_idx_q, word_idx_d;

    logic [511:0]      buf_q [2];
    logic [15:0][31:0] rd_words;
    logic              capture;
    logic              core_start;
    logic              ks_valid;
    logic              ks_xfer;
    logic              tmo_hit;

    assign ks_valid = full_q[rd_ptr_q];
    assign ks_xfer  = ks_valid & bus.ks_ready_i;
    assign tmo_hit  = (tmo_cnt_q >= CW'(TIMEOUT - 1));
    assign rd_words = buf_q[rd_ptr_q];

    always_comb begin
        state_d       = state_q;
        ctr_d         = ctr_q;
        remaining_d   = remaining_q;
        blocks_done_d = blocks_done_q;
        err_wrap_d    = err_wrap_q;
        err_tmo_d     = err_tmo_q;
        done_d        = 1'b0;
        tmo_cnt_d     = tmo_cnt_q;
        full_d        = full_q;
        last_d        = last_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        word_idx_d    = word_idx_q;
        capture       = 1'b0;
        core_start    = 1'b0;

        // Read side runs independently of the FSM so a capture and a free can coincide.
        if (ks_xfer) begin
            if (word_idx_q == 4'd15) begin
                word_idx_d        = 4'd0;
                full_d[rd_ptr_q]  = 1'b0;
                rd_ptr_d          = ~rd_ptr_q;
            end else begin
                word_idx_d = word_idx_q + 4'd1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    ctr_d         = bus.ctr_init_i;
                    remaining_d   = bus.num_blocks_i;
                    blocks_done_d = '0;
                    err_wrap_d    = 1'b0;
                    err_tmo_d     = 1'b0;
                    if (bus.num_blocks_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // Reads drain in order, so the only buffer that can be free is the write one.
                if (!full_q[wr_ptr_q]) begin
                    core_start = 1'b1;
                    tmo_cnt_d  = CW'(1);
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.core_done_i) begin
                    capture          = 1'b1;
                    full_d[wr_ptr_q] = 1'b1;
                    last_d[wr_ptr_q] = 1'b0;
                    wr_ptr_d         = ~wr_ptr_q;
                    blocks_done_d    = blocks_done_q + NB_W'(1);
                    remaining_d      = remaining_q - NB_W'(1);
                    if (remaining_q == NB_W'(1)) begin
                        last_d[wr_ptr_q] = 1'b1;
                        state_d          = S_DRAIN;
                    end else if (ctr_q == 32'hFFFF_FFFF) begin
                        err_wrap_d       = 1'b1;
                        last_d[wr_ptr_q] = 1'b1;
                        state_d          = S_DRAIN;
                    end else begin
                        ctr_d   = ctr_q + 32'd1;
                        state_d = S_ISSUE;
                    end
                end else if (tmo_hit) begin
                    // The previously captured block, if still unread, becomes the run's last.
                    err_tmo_d = 1'b1;
                    if (full_q[~wr_ptr_q]) begin
                        last_d[~wr_ptr_q] = 1'b1;
                    end
                    state_d = S_DRAIN;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                if (full_d == 2'b00) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (bus.core_done_i || tmo_hit) begin
                    state_d = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.abort_i && (state_q != S_IDLE) && (state_q != S_FLUSH)) begin
            full_d        = 2'b00;
            wr_ptr_d      = 1'b0;
            rd_ptr_d      = 1'b0;
            word_idx_d    = 4'd0;
            capture       = 1'b0;
            core_start    = 1'b0;
            done_d        = 1'b0;
            ctr_d         = ctr_q;
            remaining_d   = remaining_q;
            blocks_done_d = blocks_done_q;
            err_wrap_d    = err_wrap_q;
            err_tmo_d     = err_tmo_q;
            // A result already arriving needs no flush wait; otherwise swallow the one in flight.
            if (state_q == S_WAIT && !bus.core_done_i) begin
                state_d = S_FLUSH;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q       <= S_IDLE;
            ctr_q         <= '0;
            remaining_q   <= '0;
            blocks_done_q <= '0;
            err_wrap_q    <= 1'b0;
            err_tmo_q     <= 1'b0;
            done_q        <= 1'b0;
            tmo_cnt_q     <= '0;
            full_q        <= 2'b00;
            last_q        <= 2'b00;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            word_idx_q    <= 4'd0;
        end else begin
            state_q       <= state_d;
            ctr_q         <= ctr_d;
            remaining_q   <= remaining_d;
            blocks_done_q <= blocks_done_d;
            err_wrap_q    <= err_wrap_d;
            err_tmo_q     <= err_tmo_d;
            done_q        <= done_d;
            tmo_cnt_q     <= tmo_cnt_d;
            full_q        <= full_d;
            last_q        <= last_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            word_idx_q    <= word_idx_d;
        end
    end

    // Block storage needs no reset: its contents are only visible behind full_q.
    always_ff @(posedge wb_clk_i) begin
        if (capture) begin
            buf_q[wr_ptr_q] <= bus.core_block_i;
        end
    end

    assign bus.core_start_o  = core_start;
    assign bus.core_ctr_o    = ctr_q;
    assign bus.ks_valid_o    = ks_valid;
    assign bus.ks_data_o     = ks_valid ? rd_words[word_idx_q] : 32'd0;
    assign bus.ks_last_o     = ks_valid && (word_idx_q == 4'd15) && last_q[rd_ptr_q];
    assign bus.busy_o        = (state_q != S_IDLE);
    assign bus.done_o        = done_q;
    assign bus.err_wrap_o    = err_wrap_q;
    assign bus.err_tmo_o     = err_tmo_q;
    assign bus.blocks_done_o = blocks_done_q;
endmodule

// File: tb/tb_chacha_keystream_sched.sv
// Directed and randomized bench for chacha_keystream_sched with a behavioural core
// model and a word-level scoreboard of the expected keystream.
module tb_chacha_keystream_sched;
    localparam int NB_W = 16;
    localparam int TMO  = 64;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    chacha_keystream_sched_if #(.NB_W(NB_W)) bus ();

    chacha_keystream_sched #(.TIMEOUT(TMO), .NB_W(NB_W)) dut (
        .wb_clk_i  (clk),
        .wb_rstn_i (rstn),
        .bus       (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Job model: what the run should produce, derived from the command alone.
    int          job_nblk;
    int          job_total;
    bit          job_wrap;
    logic [31:0] job_ctr0;

    int starts_seen, words_got, done_count, last_xfer_cyc, done_cyc;

    // Core model.
    bit          core_respond, core_pend, core_discard;
    int          core_lat, core_cnt;
    logic [31:0] pend_ctr;

    int          ready_mode;
    int          stall_until;
    logic [31:0] exp_words[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: observe at the falling edge, then drive the inputs for this cycle.
    task automatic tick();
        logic [511:0] blk;
        bit rdy;
        @(negedge clk);
        cyc++;
        bus.start_i     = 1'b0;
        bus.abort_i     = 1'b0;
        bus.core_done_i = 1'b0;

        if (core_pend) begin
            check("core_ctr_held", 64'(bus.core_ctr_o), 64'(pend_ctr));
            core_cnt--;
            if (core_cnt == 0) begin
                for (int w = 0; w < 16; w++) blk[w*32 +: 32] = $urandom;
                bus.core_block_i = blk;
                bus.core_done_i  = 1'b1;
                core_pend        = 1'b0;
                if (!core_discard)
                    for (int w = 0; w < 16; w++) exp_words.push_back(blk[w*32 +: 32]);
            end
        end

        if (bus.core_start_o) begin
            check("core_ctr", 64'(bus.core_ctr_o), 64'(job_ctr0 + 32'(starts_seen)));
            starts_seen++;
            check("issue_limit", 64'((starts_seen <= job_nblk) && (starts_seen - words_got / 16 <= 2)), 64'd1);
            if (core_respond) begin
                core_pend = 1'b1;
                core_cnt  = core_lat;
                pend_ctr  = bus.core_ctr_o;
            end
        end

        case (ready_mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc >= stall_until);
            default: rdy = 1'($urandom_range(0, 1));
        endcase
        bus.ks_ready_i = rdy;

        if (bus.ks_valid_o) begin
            if (exp_words.size() == 0) begin
                check("ks_valid_unexpected", 64'(bus.ks_valid_o), 64'd0);
            end else begin
                check("ks_data", 64'(bus.ks_data_o), 64'(exp_words[0]));
                check("ks_last", 64'(bus.ks_last_o), 64'(words_got == job_total - 1));
                if (rdy) begin
                    void'(exp_words.pop_front());
                    words_got++;
                    last_xfer_cyc = cyc;
                end
            end
        end else begin
            check("ks_last_idle", 64'(bus.ks_last_o), 64'd0);
        end

        if (bus.done_o) begin
            done_count++;
            done_cyc = cyc;
        end
    endtask

    // Call right after tick(): issues start_i during the current cycle.
    task automatic begin_job(input int n, input logic [31:0] c0, input int lat,
                             input int rmode, input int stall);
        longint room;
        room          = 64'h1_0000_0000 - longint'(c0);
        job_wrap      = (longint'(n) > room);
        job_nblk      = job_wrap ? int'(room) : n;
        job_total     = 16 * job_nblk;
        job_ctr0      = c0;
        starts_seen   = 0;
        words_got     = 0;
        done_count    = 0;
        last_xfer_cyc = -1;
        done_cyc      = -1;
        exp_words.delete();
        core_pend     = 1'b0;
        core_respond  = 1'b1;
        core_discard  = 1'b0;
        core_lat      = lat;
        ready_mode    = rmode;
        stall_until   = cyc + stall;
        bus.num_blocks_i = NB_W'(n);
        bus.ctr_init_i   = c0;
        bus.start_i      = 1'b1;
    endtask

    task automatic finish_job(input string tag, input int bound);
        int t;
        t = 0;
        while (done_count == 0 && t < bound) begin
            tick();
            t++;
        end
        check({tag, "_done_seen"}, 64'(done_count), 64'd1);
        check({tag, "_words"}, 64'(words_got), 64'(job_total));
        check({tag, "_starts"}, 64'(starts_seen), 64'(job_nblk));
        check({tag, "_blocks_done"}, 64'(bus.blocks_done_o), 64'(job_nblk));
        check({tag, "_err_wrap"}, 64'(bus.err_wrap_o), 64'(job_wrap));
        check({tag, "_err_tmo"}, 64'(bus.err_tmo_o), 64'd0);
        if (job_total > 0) check({tag, "_done_latency"}, 64'(done_cyc), 64'(last_xfer_cyc + 1));
        tick();
        check({tag, "_busy_after"}, 64'(bus.busy_o), 64'd0);
        check({tag, "_done_pulse"}, 64'(bus.done_o), 64'd0);
        repeat (3) tick();
        check({tag, "_done_once"}, 64'(done_count), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_core_start"}, 64'(bus.core_start_o), 64'd0);
        check({tag, "_core_ctr"}, 64'(bus.core_ctr_o), 64'd0);
        check({tag, "_ks_valid"}, 64'(bus.ks_valid_o), 64'd0);
        check({tag, "_ks_data"}, 64'(bus.ks_data_o), 64'd0);
        check({tag, "_ks_last"}, 64'(bus.ks_last_o), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy_o), 64'd0);
        check({tag, "_done"}, 64'(bus.done_o), 64'd0);
        check({tag, "_err_wrap"}, 64'(bus.err_wrap_o), 64'd0);
        check({tag, "_err_tmo"}, 64'(bus.err_tmo_o), 64'd0);
        check({tag, "_blocks_done"}, 64'(bus.blocks_done_o), 64'd0);
    endtask

    initial begin
        int t;
        int n;
        int lat;
        logic [31:0] c0;
        bus.start_i      = 1'b0;
        bus.abort_i      = 1'b0;
        bus.num_blocks_i = '0;
        bus.ctr_init_i   = '0;
        bus.core_done_i  = 1'b0;
        bus.core_block_i = '0;
        bus.ks_ready_i   = 1'b0;
        job_nblk = 0; job_total = 0; job_wrap = 1'b0; job_ctr0 = '0;
        starts_seen = 0; words_got = 0; done_count = 0;
        core_pend = 1'b0; core_respond = 1'b1; core_discard = 1'b0; core_lat = 1;
        ready_mode = 0; stall_until = 0;

        // Reset state
        repeat (3) tick();
        check_all_zero("reset");
        rstn = 1'b1;
        tick();

        // Single block, counter 5, core latency 20
        begin_job(1, 32'd5, 20, 0, 0);
        tick();
        check("single_core_start", 64'(bus.core_start_o), 64'd1);
        check("single_busy", 64'(bus.busy_o), 64'd1);
        finish_job("single", 300);

        // Back-pressure: consumer stalled for 200 cycles
        begin_job(4, 32'd0, 10, 1, 200);
        repeat (199) tick();
        check("bp_starts_during_stall", 64'(starts_seen), 64'd2);
        check("bp_busy", 64'(bus.busy_o), 64'd1);
        finish_job("backpressure", 600);

        // Counter wrap
        begin_job(3, 32'hFFFF_FFFE, 4, 2, 0);
        finish_job("wrap", 600);

        // Zero-block request
        begin_job(0, 32'd7, 3, 0, 0);
        tick();
        check("zero_done", 64'(bus.done_o), 64'd1);
        check("zero_busy", 64'(bus.busy_o), 64'd0);
        check("zero_core_start", 64'(bus.core_start_o), 64'd0);
        finish_job("zero", 10);

        // Core timeout
        begin_job(1, 32'd100, 1, 0, 0);
        core_respond = 1'b0;
        tick();
        check("tmo_core_start", 64'(bus.core_start_o), 64'd1);
        repeat (TMO - 1) tick();
        check("tmo_flag_early", 64'(bus.err_tmo_o), 64'd0);
        tick();
        check("tmo_flag", 64'(bus.err_tmo_o), 64'd1);
        t = 0;
        while (done_count == 0 && t < 10) begin
            tick();
            t++;
        end
        check("tmo_done_seen", 64'(done_count), 64'd1);
        tick();
        check("tmo_busy", 64'(bus.busy_o), 64'd0);
        check("tmo_words", 64'(words_got), 64'd0);
        check("tmo_blocks_done", 64'(bus.blocks_done_o), 64'd0);
        check("tmo_flag_sticky", 64'(bus.err_tmo_o), 64'd1);

        // Abort while waiting on the core; its late result must be swallowed
        begin_job(2, 32'd40, 15, 0, 0);
        core_discard = 1'b1;
        tick();
        check("abort_core_start", 64'(bus.core_start_o), 64'd1);
        repeat (5) tick();
        bus.abort_i = 1'b1;
        repeat (9) tick();
        check("abort_busy_flush", 64'(bus.busy_o), 64'd1);
        tick();
        check("abort_busy_at_done", 64'(bus.busy_o), 64'd1);
        tick();
        check("abort_busy_released", 64'(bus.busy_o), 64'd0);
        repeat (5) tick();
        check("abort_no_done", 64'(done_count), 64'd0);
        check("abort_no_words", 64'(words_got), 64'd0);
        check("abort_starts", 64'(starts_seen), 64'd1);
        begin_job(1, 32'd9, 6, 0, 0);
        finish_job("after_abort", 300);

        // Reset in the middle of a block readout
        begin_job(1, 32'd77, 3, 0, 0);
        t = 0;
        while (words_got < 7 && t < 100) begin
            tick();
            t++;
        end
        check("rst_pre_valid", 64'(bus.ks_valid_o), 64'd1);
        #2 rstn = 1'b0;
        #1;
        check_all_zero("rst_async");
        core_pend = 1'b0;
        exp_words.delete();
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        begin_job(1, 32'd3, 5, 0, 0);
        finish_job("after_reset", 300);

        // Randomized runs with random ready, latency and counters near the wrap point
        for (int r = 0; r < 6; r++) begin
            n   = $urandom_range(1, 5);
            lat = $urandom_range(1, 30);
            if ($urandom_range(0, 2) == 0) c0 = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            else                          c0 = $urandom;
            begin_job(n, c0, lat, 2, 0);
            finish_job("random", 3000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
